// File: rtl/onehot_dispatch.sv
// Buffers 5-bit encoded channel indices and replays them as timed one-hot pulses.
// Optional `DISPATCH_CNT_EN adds a 16-bit count of dispatched (non-null) pulses.
module onehot_dispatch #(
    parameter int unsigned PULSE_LEN  = 2,
    parameter int unsigned GAP_LEN    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    idx_in,
    input  logic                          idx_valid,
    output logic                          idx_ready,
    output logic [15:0]                   out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
`ifdef DISPATCH_CNT_EN
    ,
    output logic [15:0]                   dispatch_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        out_d;
    logic [4:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [LVL_W-1:0]   level_q;
    logic [4:0]         head;
    logic               full, empty, push, pop, dispatch;

    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty     = (level_q == '0);
    assign head      = mem[rd_ptr];
    assign idx_ready = !full && !rst;
    assign push      = idx_valid && idx_ready;
    assign busy      = (state_q != IDLE) || !empty;
    assign level     = level_q;

    // Next-state / pulse timing; a null head is popped in IDLE without leaving IDLE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out;
        pop      = 1'b0;
        dispatch = 1'b0;
        case (state_q)
            IDLE: begin
                out_d = '0;
                if (!empty) begin
                    pop = 1'b1;
                    if (!head[4]) begin
                        out_d    = 16'h0001 << head[3:0];
                        cnt_d    = CNT_W'(PULSE_LEN - 1);
                        state_d  = DRIVE;
                        dispatch = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    out_d = '0;
                    if (GAP_LEN > 0) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_LEN - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                out_d = '0;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                out_d   = '0;
            end
        endcase
    end

    // State, pulse and FIFO bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out     <= out_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by level_q.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= idx_in;
    end

`ifdef DISPATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dispatch_cnt <= '0;
        end else if (dispatch) begin
            dispatch_cnt <= dispatch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_dispatch.sv
// Scoreboard bench for onehot_dispatch: a timeline model schedules each accepted
// command, a negedge monitor pops expectations whenever a pulse appears.
module tb_onehot_dispatch;

    localparam int P = 2;
    localparam int G = 1;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  idx_in;
    logic        idx_valid;
    logic        idx_ready;
    logic [15:0] out;
    logic        busy;
    logic [2:0]  level;
`ifdef DISPATCH_CNT_EN
    logic [15:0] dispatch_cnt;
`endif

    onehot_dispatch #(.PULSE_LEN(P), .GAP_LEN(G), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .idx_in    (idx_in),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .out       (out),
        .busy      (busy),
        .level     (level)
`ifdef DISPATCH_CNT_EN
        ,
        .dispatch_cnt (dispatch_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          start;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   pop_q[$];
    int   chan_q[$];
    int   edge_n     = 0;
    int   free_edge  = 0;
    int   busy_until = 0;
    int   rst_edge   = -1;
    int   tests      = 0;
    int   fails      = 0;
    int   exp_cnt    = 0;
    int   plen       = 0;
    logic [15:0] prev_out = '0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Reference model: each command pops at the earliest edge the block is free;
    // a channel occupies P+G+1 edges, a null exactly one.
    always @(posedge clk) begin
        int s;
        edge_n++;
        if (rst) begin
            exp_q.delete();
            pop_q.delete();
            chan_q.delete();
            free_edge  = edge_n + 1;
            busy_until = 0;
            rst_edge   = edge_n;
        end else if (idx_valid && idx_ready) begin
            s = (edge_n + 1 > free_edge) ? edge_n + 1 : free_edge;
            pop_q.push_back(s);
            if (!idx_in[4]) begin
                exp_q.push_back('{start: s, val: 16'(1) << idx_in[3:0]});
                chan_q.push_back(s);
                free_edge  = s + P + G + 1;
                busy_until = s + P + G;
            end else begin
                free_edge = s + 1;
            end
        end
    end

    // Monitor: compares flags every cycle and pops an expectation per pulse.
    always @(negedge clk) begin
        bit rst_now;
        rst_now = (rst_edge == edge_n);
        if (rst_now) exp_cnt = 0;
        while (pop_q.size() != 0 && pop_q[0] <= edge_n) void'(pop_q.pop_front());
        while (chan_q.size() != 0 && chan_q[0] <= edge_n) begin
            void'(chan_q.pop_front());
            exp_cnt++;
        end
        chk("level", int'(level), pop_q.size());
        chk("idx_ready", int'(idx_ready), int'(!rst && pop_q.size() < D));
        chk("busy", int'(busy), int'(pop_q.size() != 0 || edge_n < busy_until));
        chk("onehot0", int'($onehot0(out)), 1);
`ifdef DISPATCH_CNT_EN
        chk("dispatch_cnt", int'(dispatch_cnt), exp_cnt & 16'hFFFF);
`endif
        if (out != 0 && prev_out == 0) begin
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", int'(out), 0);
            end else begin
                chk("pulse_value", int'(out), int'(exp_q[0].val));
                chk("pulse_start", edge_n, exp_q[0].start);
                void'(exp_q.pop_front());
            end
            plen = 1;
        end else if (out != 0) begin
            chk("pulse_stable", int'(out), int'(prev_out));
            plen++;
        end else begin
            if (prev_out != 0 && !rst_now) chk("pulse_len", plen, P);
            if (exp_q.size() != 0 && exp_q[0].start <= edge_n) begin
                chk("missed_pulse", int'(out), int'(exp_q[0].val));
                void'(exp_q.pop_front());
            end
        end
        prev_out = out;
    end

    task automatic send(input logic [4:0] idx, input bit hold);
        bit acc;
        acc       = 1'b0;
        idx_in    = idx;
        idx_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            if (idx_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("accept_timeout", 0, 1);
        #1;
        if (!hold) idx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0 && pop_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", int'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        idx_valid = 1'b0;
        idx_in    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single command, idx 3
        send(5'd3, 1'b0);
        wait_drain();

        // Walk 0..15 with idx_valid held
        for (int i = 0; i < 16; i++) send(5'(i), 1'b1);
        idx_valid = 1'b0;
        wait_drain();

        // Null commands then a channel
        send(5'd16, 1'b1);
        send(5'd31, 1'b1);
        send(5'd5, 1'b0);
        wait_drain();

        // Backpressure: 6 back-to-back commands fill the FIFO
        for (int i = 0; i < 6; i++) send(5'(i + 8), 1'b1);
        idx_valid = 1'b0;
        wait_drain();

        // Reset during the second DRIVE cycle with commands queued
        for (int i = 0; i < 4; i++) send(5'(i + 1), 1'b1);
        idx_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out != 0) break;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Randomized traffic with ~20% null commands and random valid gaps
        for (int n = 0; n < 150; n++) begin
            logic [4:0] idx;
            if ($urandom_range(0, 4) == 0) idx = 5'(16 + $urandom_range(0, 15));
            else                           idx = 5'($urandom_range(0, 15));
            send(idx, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                idx_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        idx_valid = 1'b0;
        wait_drain();

        chk("leftover_pulses", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
